data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory end of the CPU's data-memory request interface (enable / wr / addr / data_in / data_out).
- Latches one request, holds it for LATENCY cycles with stall raised, then performs the array access and pulses data_valid.
- Lets the CPU datapath be verified against non-zero memory latency before the pipelined core's stall logic exists.

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches one request, stalls for LATENCY cycles,
// then accesses the word array and pulses data_valid. Optional DATA_MEM_ALIGN_CHECK_EN flags odd addresses.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        stall,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic              req_wr_reg;
  logic [ADDR_W-1:0] req_idx_reg;
  logic [15:0]       req_data_reg;

  logic [15:0] data_out_reg;
  logic        data_valid_reg, data_valid_next;
  logic        stall_reg, stall_next;
  logic        err_reg, err_next;

  logic accept;
  logic do_access;
  logic access_en;
  logic misalign;

  logic [15:0] mem [DEPTH];

  // Upper address bits alias by design; addr[0] only matters with the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    accept          = 1'b0;
    do_access       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (enable) begin
          accept     = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          do_access  = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered: derive them from where the FSM is heading.
  always_comb begin
    stall_next      = (state_next == BUSY);
    data_valid_next = do_access;
    err_next        = do_access && misalign;
  end

  assign access_en = do_access && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      data_valid_reg <= 1'b0;
      stall_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      data_valid_reg <= data_valid_next;
      stall_reg      <= stall_next;
      err_reg        <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_wr_reg   <= wr;
      req_idx_reg  <= addr[ADDR_W:1];
      req_data_reg <= data_in;
    end
  end

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic req_odd_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      req_odd_reg <= addr[0];
    end
  end

  assign misalign = req_odd_reg;
`else
  assign misalign = 1'b0;
`endif

  // Array without reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (access_en && req_wr_reg && !misalign) begin
      mem[req_idx_reg] <= req_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg <= 16'h0000;
    end else if (access_en && !req_wr_reg && !misalign) begin
      data_out_reg <= mem[req_idx_reg];
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign stall      = stall_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference model.
// Honours DATA_MEM_ALIGN_CHECK_EN when the same define is given to the build.
module tb_data_mem_responder;

  localparam int AW    = 10;
  localparam int L     = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic        err;

  int checks;
  int failures;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_dout;

  data_mem_responder #(
    .ADDR_W (AW),
    .LATENCY(L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .stall     (stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  function automatic bit is_misaligned(input logic [15:0] a);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    return a[0];
`else
    return 1'b0;
`endif
  endfunction

  // Idle cycles: no response may appear and data_out must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'b0;
      @(negedge clk);
      check_eq("idle_valid", 16'(data_valid), 16'h0);
      check_eq("idle_stall", 16'(stall), 16'h0);
      check_eq("idle_err", 16'(err), 16'h0);
      check_eq("idle_dout", data_out, exp_dout);
    end
  endtask

  // Called at a negedge in an IDLE or DONE cycle; returns at the negedge of the DONE cycle.
  // noise: 0 none, 1 write of FFFF to the same address at E2, 2 random junk every busy cycle.
  task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d, input int noise,
                     input bit quiet);
    bit mis;
    enable  = 1'b1;
    wr      = w;
    addr    = a;
    data_in = d;
    @(negedge clk);
    for (int i = 0; i < L; i++) begin
      check_eq("busy_stall", 16'(stall), 16'h1);
      check_eq("busy_valid", 16'(data_valid), 16'h0);
      check_eq("busy_err", 16'(err), 16'h0);
      if (noise == 1 && i == 1) begin
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = a;
        data_in = 16'hFFFF;
      end else if (noise == 2) begin
        enable  = 1'($urandom_range(0, 1));
        wr      = 1'($urandom_range(0, 1));
        addr    = 16'($urandom);
        data_in = 16'($urandom);
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    enable = 1'b0;
    mis = is_misaligned(a);
    if (!mis) begin
      if (w) model_mem[word_idx(a)] = d;
      else   exp_dout = model_mem[word_idx(a)];
    end
    check_eq("done_valid", 16'(data_valid), 16'h1);
    check_eq("done_stall", 16'(stall), 16'h0);
    check_eq("done_err", 16'(err), 16'(mis));
    check_eq("done_dout", data_out, exp_dout);
    if (!quiet)
      $display("req %s addr=%h data=%h dout=%h err=%0d", w ? "WR" : "RD", a, d, data_out, err);
  endtask

  // Write accepted, then reset asserted so it lands on E2: the write must be discarded.
  task automatic req_reset_mid(input logic [15:0] a, input logic [15:0] d);
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dout = 16'h0000;
    check_eq("rstmid_stall", 16'(stall), 16'h0);
    check_eq("rstmid_valid", 16'(data_valid), 16'h0);
    check_eq("rstmid_dout", data_out, 16'h0000);
    $display("req WR addr=%h data=%h aborted by reset", a, d);
    idle(L + 2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_dout = 16'h0000;
    rst      = 1'b1;
    enable   = 1'b0;
    wr       = 1'b0;
    addr     = 16'h0000;
    data_in  = 16'h0000;

    repeat (2) begin
      @(negedge clk);
      check_eq("rst_dout", data_out, 16'h0000);
      check_eq("rst_stall", 16'(stall), 16'h0);
      check_eq("rst_valid", 16'(data_valid), 16'h0);
      check_eq("rst_err", 16'(err), 16'h0);
    end
    rst = 1'b0;
    idle(2);

    // Known contents everywhere; random upper bits exercise aliasing on writes.
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] hi;
      hi = 16'($urandom_range(0, 31)) << (AW + 1);
      req(1'b1, hi | 16'(i * 2), 16'($urandom), 0, 1'b1);
    end
    $display("prefill of %0d words complete", DEPTH);
    idle(1);

    req(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
    req(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    idle(1);

    req(1'b1, 16'h0020, 16'h1234, 0, 1'b0);
    idle(1);
    req(1'b0, 16'h0020, 16'h0000, 1, 1'b0);
    idle(2);
    req(1'b0, 16'h0020, 16'h0000, 0, 1'b0);
    check_eq("noise_read", data_out, 16'h1234);

    req(1'b1, 16'h0802, 16'h5A5A, 0, 1'b0);
    req(1'b0, 16'h0002, 16'h0000, 0, 1'b0);
    check_eq("alias_read", data_out, 16'h5A5A);

    req(1'b1, 16'h0040, 16'h0001, 0, 1'b0);
    idle(1);
    req_reset_mid(16'h0040, 16'h7777);
    req(1'b0, 16'h0040, 16'h0000, 0, 1'b0);
    check_eq("rstmid_read", data_out, 16'h0001);

    req(1'b1, 16'h0030, 16'h0000, 0, 1'b0);
    req(1'b1, 16'h0031, 16'hAAAA, 0, 1'b0);
    req(1'b0, 16'h0030, 16'h0000, 0, 1'b0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    check_eq("align_read", data_out, 16'h0000);
`else
    check_eq("align_read", data_out, 16'hAAAA);
`endif

    for (int n = 0; n < 200; n++) begin
      req(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
          ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
